// File: rtl/nfault_pkg.sv
// nfault_pkg: shared state encoding, default parameters and popcount helper
// for the nFault sequencer (nfault_manager and fault_priority_encoder).
package nfault_pkg;

   // Sequencer states: idle, assert, minimum hold, latched, release gap
   typedef enum logic [2:0] {
      S_F0 = 3'd0,
      S_F1 = 3'd1,
      S_F2 = 3'd2,
      S_F3 = 3'd3,
      S_F4 = 3'd4
   } fault_state_t;

   localparam int DEF_NUM_SUBSYS        = 4;
   localparam int DEF_MIN_ASSERT_CYCLES = 8;
   localparam int DEF_RELEASE_GAP       = 2;
   localparam int DEF_COUNT_WIDTH       = 8;

   // Widest request vector popcount handles; NUM_SUBSYS must not exceed it
   localparam int POP_W = 64;

   function automatic int unsigned popcount(input logic [POP_W-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < POP_W; i++) n += 32'(v[i]);
      return n;
   endfunction

endpackage

// File: rtl/nfault_manager_priority_encoder.sv
// fault_priority_encoder: combinational lowest-index-wins encoder used to
// pick the first fault source when several requests arrive together.
module fault_priority_encoder #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   output logic [IW-1:0] idx,
   output logic          valid
);

   // Scan from the top down so the lowest set bit is the last to write idx
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = IW'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/nfault_manager.sv
// nfault_manager: sticky fault status, first-fault capture, saturating
// rising-edge counter and the nFault assert / hold / latch / gap sequencer.
// Optional build macro NFAULT_MASK_EN adds a fault_mask register that hides
// masked sources from the sequencer and first-fault capture.
module nfault_manager
   import nfault_pkg::*;
#(
   parameter  int NUM_SUBSYS        = DEF_NUM_SUBSYS,
   parameter  int MIN_ASSERT_CYCLES = DEF_MIN_ASSERT_CYCLES,
   parameter  int RELEASE_GAP       = DEF_RELEASE_GAP,
   parameter  int COUNT_WIDTH       = DEF_COUNT_WIDTH,
   localparam int ID_W              = $clog2(NUM_SUBSYS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_SUBSYS-1:0]  fault_req,
   input  logic                   clear_strobe,
   input  logic [NUM_SUBSYS-1:0]  clear_mask,
`ifdef NFAULT_MASK_EN
   input  logic                   mask_load,
   input  logic [NUM_SUBSYS-1:0]  mask_data,
`endif
   output logic                   nFault_oe,
   output logic                   fault_active,
   output logic [NUM_SUBSYS-1:0]  fault_status,
   output logic [ID_W-1:0]        first_fault_id,
   output logic                   first_fault_valid,
   output logic [COUNT_WIDTH-1:0] fault_count
);

   // Hold and gap share one down-counter sized for the longer of the two
   localparam int TMR_MAX = (MIN_ASSERT_CYCLES > RELEASE_GAP) ? MIN_ASSERT_CYCLES : RELEASE_GAP;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

   fault_state_t          state_q, state_d;
   logic [TMR_W-1:0]      tmr_q, tmr_d;
   logic                  oe_d;
   logic [NUM_SUBSYS-1:0] req_q;
   logic [NUM_SUBSYS-1:0] status_d;
   logic [NUM_SUBSYS-1:0] rise;
   logic [NUM_SUBSYS-1:0] fault_mask;
   logic [NUM_SUBSYS-1:0] eff_status;
   logic [NUM_SUBSYS-1:0] eff_req;
   logic [ID_W-1:0]       enc_idx;
   logic                  enc_valid;
   logic [31:0]           cnt_sum;

`ifdef NFAULT_MASK_EN
   logic [NUM_SUBSYS-1:0] fault_mask_q;

   // Mask register, loaded from the bus; reset leaves every source unmasked
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          fault_mask_q <= '0;
      else if (mask_load) fault_mask_q <= mask_data;
   end

   assign fault_mask = fault_mask_q;
`else
   assign fault_mask = '0;
`endif

   // Masked sources still latch and count; they are only hidden from the
   // sequencer and from first-fault capture
   assign eff_status = fault_status & ~fault_mask;
   assign eff_req    = fault_req & ~fault_mask;

   // Set has priority over clear, so a held request survives a clear
   assign status_d = (fault_status & ~({NUM_SUBSYS{clear_strobe}} & clear_mask)) | fault_req;
   assign rise     = fault_req & ~req_q;
   assign cnt_sum  = 32'(fault_count) + popcount(POP_W'(rise));

   fault_priority_encoder #(.N(NUM_SUBSYS)) u_enc (
      .req   (eff_req),
      .idx   (enc_idx),
      .valid (enc_valid)
   );

   // Sticky status and edge-detect history
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fault_status <= '0;
         req_q        <= '0;
      end else begin
         fault_status <= status_d;
         req_q        <= fault_req;
      end
   end

   // First-fault capture: armed while invalid, drops when status empties
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         first_fault_valid <= 1'b0;
         first_fault_id    <= '0;
      end else if (!first_fault_valid && enc_valid) begin
         first_fault_valid <= 1'b1;
         first_fault_id    <= enc_idx;
      end else if (status_d == '0) begin
         first_fault_valid <= 1'b0;
      end
   end

   // Saturating count of request rising edges; the sum is computed wide so a
   // burst of simultaneous edges cannot wrap a narrow counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                         fault_count <= '0;
      else if (cnt_sum > 32'(CNT_MAX))   fault_count <= CNT_MAX;
      else                               fault_count <= cnt_sum[COUNT_WIDTH-1:0];
   end

   // Sequencer state and hold/gap timer registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_F0;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
      end
   end

   // Next-state logic; a timer loaded with N-1 keeps its state for N clocks
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      case (state_q)
         S_F0: if (eff_status != '0) state_d = S_F1;
         S_F1: begin
            tmr_d   = TMR_W'(MIN_ASSERT_CYCLES - 1);
            state_d = S_F2;
         end
         S_F2: begin
            if (tmr_q == '0) state_d = S_F3;
            else             tmr_d   = tmr_q - TMR_W'(1);
         end
         S_F3: begin
            if (eff_status == '0) begin
               tmr_d   = TMR_W'(RELEASE_GAP - 1);
               state_d = S_F4;
            end
         end
         S_F4: begin
            if (tmr_q == '0) state_d = S_F0;
            else             tmr_d   = tmr_q - TMR_W'(1);
         end
         default: begin
            state_d = S_F0;
            tmr_d   = '0;
         end
      endcase
   end

   // Moore output decode of the current state
   always_comb begin
      oe_d         = (state_q == S_F1) || (state_q == S_F2) || (state_q == S_F3);
      fault_active = (state_q != S_F0);
   end

   // Pad enable is registered so the pin never sees decode glitches;
   // asynchronous reset releases it immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) nFault_oe <= 1'b0;
      else       nFault_oe <= oe_d;
   end

endmodule

// File: tb/tb_nfault_manager.sv
// tb_nfault_manager: directed scenarios plus random traffic, checked against a
// timeline-based reference model of the nFault sequencer.
module tb_nfault_manager;

   localparam int N   = 4;
   localparam int MIN = 8;
   localparam int GAP = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [N-1:0] fault_req = '0;
   logic       clear_strobe = 1'b0;
   logic [N-1:0] clear_mask = '0;

   logic       oe_a, act_a, ffv_a;
   logic [N-1:0] st_a;
   logic [1:0] ffid_a;
   logic [7:0] cnt_a;
   logic       oe_b, act_b, ffv_b;
   logic [N-1:0] st_b;
   logic [1:0] ffid_b;
   logic [1:0] cnt_b;

   int total = 0;
   int bad   = 0;

   // Reference model: mode 0 idle, 1 pin asserted (assert/hold/latched), 2 gap
   logic [N-1:0] m_st, m_req_q;
   int           m_cnt, m_cnt_s;
   logic         m_ffv;
   logic [1:0]   m_ffid;
   int           m_mode, m_t1, m_rel, k;
   logic         m_oe;

   always #5 clk = ~clk;

   nfault_manager #(.NUM_SUBSYS(N), .MIN_ASSERT_CYCLES(MIN), .RELEASE_GAP(GAP), .COUNT_WIDTH(8)) u_dut (
      .clk(clk), .reset(reset), .fault_req(fault_req), .clear_strobe(clear_strobe), .clear_mask(clear_mask),
`ifdef NFAULT_MASK_EN
      .mask_load(1'b0), .mask_data('0),
`endif
      .nFault_oe(oe_a), .fault_active(act_a), .fault_status(st_a), .first_fault_id(ffid_a),
      .first_fault_valid(ffv_a), .fault_count(cnt_a));

   nfault_manager #(.NUM_SUBSYS(N), .MIN_ASSERT_CYCLES(MIN), .RELEASE_GAP(GAP), .COUNT_WIDTH(2)) u_sat (
      .clk(clk), .reset(reset), .fault_req(fault_req), .clear_strobe(clear_strobe), .clear_mask(clear_mask),
`ifdef NFAULT_MASK_EN
      .mask_load(1'b0), .mask_data('0),
`endif
      .nFault_oe(oe_b), .fault_active(act_b), .fault_status(st_b), .first_fault_id(ffid_b),
      .first_fault_valid(ffv_b), .fault_count(cnt_b));

   function automatic void model_reset();
      m_st = '0; m_req_q = '0; m_cnt = 0; m_cnt_s = 0; m_ffv = 1'b0; m_ffid = '0;
      m_mode = 0; m_t1 = 0; m_rel = 0; k = 0; m_oe = 1'b0;
   endfunction

   // One clock edge of the model, using the inputs present at that edge.
   // The pin rises two edges after status is seen while idle, stays up until
   // the hold (1 assert + MIN hold clocks) is over and status is empty, then
   // drops one edge after that and stays down for the GAP-clock release gap.
   function automatic void model_step();
      int old_mode = m_mode;
      int r;
      int id;
      k++;
      case (m_mode)
         0: if (m_st != '0) begin m_mode = 1; m_t1 = k; end
         1: if ((k - 1 >= m_t1 + MIN + 1) && (m_st == '0)) begin m_mode = 2; m_rel = k; end
         default: if (k == m_rel + GAP) m_mode = 0;
      endcase
      m_oe = (old_mode == 1);
      r = $countones(fault_req & ~m_req_q);
      m_cnt   = (m_cnt + r > 255) ? 255 : m_cnt + r;
      m_cnt_s = (m_cnt_s + r > 3) ? 3 : m_cnt_s + r;
      m_req_q = fault_req;
      m_st = (m_st & ~(clear_strobe ? clear_mask : '0)) | fault_req;
      if (!m_ffv && fault_req != '0) begin
         id = 0;
         while (!fault_req[id]) id++;
         m_ffid = 2'(id);
         m_ffv  = 1'b1;
      end else if (m_st == '0) begin
         m_ffv = 1'b0;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; fault_req = '0; clear_strobe = 1'b0; clear_mask = '0;
      @(posedge clk); #1;
      model_reset();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; fault_req = '0; clear_strobe = 1'b0; clear_mask = '0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (oe_a !== 1'b0)   begin bad++; $display("FAIL reset_oe got=%b exp=0", oe_a); end
      total++; if (act_a !== 1'b0)  begin bad++; $display("FAIL reset_active got=%b exp=0", act_a); end
      total++; if (st_a !== 4'b0)   begin bad++; $display("FAIL reset_status got=%b exp=0000", st_a); end
      total++; if ({ffv_a, ffid_a} !== 3'b0) begin bad++; $display("FAIL reset_first got=%b exp=000", {ffv_a, ffid_a}); end
      total++; if (cnt_a !== 8'd0)  begin bad++; $display("FAIL reset_count got=%0d exp=0", cnt_a); end
      model_reset();
      reset = 1'b0;
   endtask

   task automatic test_single_pulse();
      int hi = 0;
      do_reset();
      fault_req = 4'b0100; tick(); fault_req = '0;
      total++; if (st_a !== 4'b0100) begin bad++; $display("FAIL single_status got=%b exp=0100", st_a); end
      total++; if (ffid_a !== 2'd2 || ffv_a !== 1'b1) begin bad++; $display("FAIL single_first got=%0d/%b exp=2/1", ffid_a, ffv_a); end
      total++; if (cnt_a !== 8'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", cnt_a); end
      for (int i = 0; i < 19; i++) begin
         tick();
         if (oe_a) hi++;
         total++; if (oe_a !== m_oe) begin bad++; $display("FAIL single_oe edge=%0d got=%b exp=%b", k, oe_a, m_oe); end
      end
      // pin rises on the third edge and stays up while the bit is latched
      total++; if (hi != 18) begin bad++; $display("FAIL single_hi got=%0d exp=18", hi); end
      clear_strobe = 1'b1; clear_mask = 4'b0100; tick(); clear_strobe = 1'b0; clear_mask = '0;
      total++; if (st_a !== 4'b0 || ffv_a !== 1'b0) begin bad++; $display("FAIL single_clear got=%b/%b exp=0000/0", st_a, ffv_a); end
      tick();
      total++; if (oe_a !== 1'b1) begin bad++; $display("FAIL single_rel1 got=%b exp=1", oe_a); end
      tick();
      total++; if (oe_a !== 1'b0) begin bad++; $display("FAIL single_rel2 got=%b exp=0", oe_a); end
   endtask

   task automatic test_early_clear();
      int hi = 0;
      do_reset();
      fault_req = 4'b0001; tick(); fault_req = '0;
      for (int i = 0; i < 4; i++) begin tick(); if (oe_a) hi++; end
      clear_strobe = 1'b1; clear_mask = 4'b0001; tick(); clear_strobe = 1'b0; clear_mask = '0;
      if (oe_a) hi++;
      total++; if (st_a !== 4'b0 || oe_a !== 1'b1) begin bad++; $display("FAIL early_clear got=%b/%b exp=0000/1", st_a, oe_a); end
      for (int i = 0; i < 16; i++) begin
         tick();
         if (oe_a) hi++;
         total++; if (oe_a !== m_oe || act_a !== (m_mode != 0)) begin
            bad++; $display("FAIL early_seq edge=%0d got=%b%b exp=%b%b", k, oe_a, act_a, m_oe, m_mode != 0); end
      end
      // assert clock + full hold + one latched clock noticing the empty status
      total++; if (hi != MIN + 2) begin bad++; $display("FAIL early_hi got=%0d exp=%0d", hi, MIN + 2); end
      total++; if (act_a !== 1'b0) begin bad++; $display("FAIL early_idle got=%b exp=0", act_a); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      fault_req = 4'b1010; tick(); fault_req = '0;
      total++; if (ffid_a !== 2'd1) begin bad++; $display("FAIL simul_id got=%0d exp=1", ffid_a); end
      total++; if (cnt_a !== 8'd2) begin bad++; $display("FAIL simul_count got=%0d exp=2", cnt_a); end
      repeat (12) tick();
      clear_strobe = 1'b1; clear_mask = 4'b0010; tick(); clear_strobe = 1'b0; clear_mask = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (oe_a !== 1'b1 || st_a !== 4'b1000) begin bad++; $display("FAIL simul_hold got=%b/%b exp=1/1000", oe_a, st_a); end
      end
      clear_strobe = 1'b1; clear_mask = 4'b1000; tick(); clear_strobe = 1'b0; clear_mask = '0;
      repeat (3) tick();
      total++; if (oe_a !== 1'b0 || act_a !== 1'b0) begin bad++; $display("FAIL simul_release got=%b/%b exp=0/0", oe_a, act_a); end
      total++; if (ffv_a !== 1'b0) begin bad++; $display("FAIL simul_ffv got=%b exp=0", ffv_a); end
   endtask

   task automatic test_collision();
      do_reset();
      fault_req = 4'b1000; tick(); fault_req = '0;
      repeat (12) tick();
      // request held high while clears hit the same bit every clock
      fault_req = 4'b1000; clear_strobe = 1'b1; clear_mask = 4'b1000;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++; if (st_a[3] !== 1'b1) begin bad++; $display("FAIL collide_status got=%b exp=1", st_a[3]); end
      end
      fault_req = '0; clear_strobe = 1'b0; clear_mask = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (oe_a !== 1'b1) begin bad++; $display("FAIL collide_oe got=%b exp=1", oe_a); end
      end
      total++; if (cnt_a !== 8'd2) begin bad++; $display("FAIL collide_count got=%0d exp=2", cnt_a); end
      clear_strobe = 1'b1; clear_mask = 4'b1000; tick(); clear_strobe = 1'b0; clear_mask = '0;
      repeat (3) tick();
      total++; if (oe_a !== 1'b0) begin bad++; $display("FAIL collide_release got=%b exp=0", oe_a); end
   endtask

   task automatic test_gap_rearm();
      do_reset();
      fault_req = 4'b0010; tick(); fault_req = '0;
      repeat (11) tick();
      clear_strobe = 1'b1; clear_mask = 4'b0010; tick(); clear_strobe = 1'b0; clear_mask = '0;
      tick();
      total++; if (oe_a !== 1'b1) begin bad++; $display("FAIL gap_last_hi got=%b exp=1", oe_a); end
      fault_req = 4'b0010; tick(); fault_req = '0;
      total++; if (oe_a !== 1'b0 || act_a !== 1'b1 || st_a !== 4'b0010) begin
         bad++; $display("FAIL gap_first got=%b/%b/%b exp=0/1/0010", oe_a, act_a, st_a); end
      tick();
      total++; if (oe_a !== 1'b0 || act_a !== 1'b0) begin bad++; $display("FAIL gap_idle got=%b/%b exp=0/0", oe_a, act_a); end
      tick();
      total++; if (oe_a !== 1'b0 || act_a !== 1'b1) begin bad++; $display("FAIL gap_assert got=%b/%b exp=0/1", oe_a, act_a); end
      tick();
      total++; if (oe_a !== 1'b1) begin bad++; $display("FAIL gap_rearm got=%b exp=1", oe_a); end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 5; i++) begin fault_req = 4'b0001; tick(); fault_req = '0; tick(); end
      total++; if (cnt_b !== 2'd3) begin bad++; $display("FAIL sat_narrow got=%0d exp=3", cnt_b); end
      total++; if (cnt_a !== 8'd5) begin bad++; $display("FAIL sat_wide got=%0d exp=5", cnt_a); end
      fault_req = 4'b1111; tick(); fault_req = '0; tick();
      total++; if (cnt_a !== 8'd9 || cnt_b !== 2'd3) begin bad++; $display("FAIL sat_burst got=%0d/%0d exp=9/3", cnt_a, cnt_b); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      fault_req = 4'b0001; tick(); fault_req = '0;
      repeat (5) tick();
      total++; if (oe_a !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b exp=1", oe_a); end
      #2 reset = 1'b1;
      #1;
      total++; if (oe_a !== 1'b0 || st_a !== 4'b0 || act_a !== 1'b0) begin
         bad++; $display("FAIL rstmid_async got=%b/%b/%b exp=0/0000/0", oe_a, st_a, act_a); end
      @(posedge clk); #1;
      model_reset();
      reset = 1'b0;
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 500; n++) begin
         fault_req    = ($urandom_range(0, 5) == 0) ? 4'($urandom) : '0;
         clear_strobe = ($urandom_range(0, 3) == 0);
         clear_mask   = 4'($urandom);
         tick();
         total++; if (st_a !== m_st) begin bad++; $display("FAIL rnd_status edge=%0d got=%b exp=%b", k, st_a, m_st); end
         total++; if (oe_a !== m_oe || act_a !== (m_mode != 0)) begin
            bad++; $display("FAIL rnd_fsm edge=%0d got=%b%b exp=%b%b", k, oe_a, act_a, m_oe, m_mode != 0); end
         total++; if (ffv_a !== m_ffv || (m_ffv && ffid_a !== m_ffid)) begin
            bad++; $display("FAIL rnd_first edge=%0d got=%b/%0d exp=%b/%0d", k, ffv_a, ffid_a, m_ffv, m_ffid); end
         total++; if (cnt_a !== 8'(m_cnt) || cnt_b !== 2'(m_cnt_s)) begin
            bad++; $display("FAIL rnd_count edge=%0d got=%0d/%0d exp=%0d/%0d", k, cnt_a, cnt_b, m_cnt, m_cnt_s); end
         total++; if ({oe_b, act_b, st_b, ffv_b} !== {m_oe, m_mode != 0, m_st, m_ffv} || (m_ffv && ffid_b !== m_ffid)) begin
            bad++; $display("FAIL rnd_narrow edge=%0d got=%b%b%b%b exp=%b%b%b%b", k, oe_b, act_b, st_b, ffv_b, m_oe, m_mode != 0, m_st, m_ffv); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_pulse();
      test_early_clear();
      test_simultaneous();
      test_collision();
      test_gap_rearm();
      test_saturation();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
